// File: rtl/arbitro_pkg.sv
// -----------------------------------------------------------------------------
// arbitro_pkg
// Shared definitions for the nRisc memory arbiter:
//   - sequencer state encoding (OCIOSO / ACESSO / ESPERA)
//   - grant encoding (NENHUM / CARGA / DADO / BUSCA)
//   - legal bounds for the memory read latency and a range-check helper
// -----------------------------------------------------------------------------
package arbitro_pkg;

    // Sequencer states
    localparam logic [1:0] OCIOSO = 2'd0;
    localparam logic [1:0] ACESSO = 2'd1;
    localparam logic [1:0] ESPERA = 2'd2;

    // Grant codes
    localparam logic [1:0] NENHUM = 2'd0;
    localparam logic [1:0] CARGA  = 2'd1;
    localparam logic [1:0] DADO   = 2'd2;
    localparam logic [1:0] BUSCA  = 2'd3;

    // Memory read latency bounds (cycles)
    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 4;

    function automatic bit mem_lat_valida(input int lat);
        return (lat >= MEM_LAT_MIN) && (lat <= MEM_LAT_MAX);
    endfunction

endpackage

// File: rtl/arbitro_memoria_seletor.sv
// -----------------------------------------------------------------------------
// seletor_prioridade
// Combinational grant selection for the memory arbiter.
//   i_carga_req   : loader request (always wins)
//   i_dado_req    : data load/store request
//   i_busca_req   : instruction fetch request
//   i_ultimo_dado : 1 when the most recent Dado/Busca grant went to Dado
//   o_grant       : selected requester (NENHUM when nobody asks)
// -----------------------------------------------------------------------------
module seletor_prioridade
    import arbitro_pkg::*;
(
    input  logic       i_carga_req,
    input  logic       i_dado_req,
    input  logic       i_busca_req,
    input  logic       i_ultimo_dado,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = NENHUM;
        if (i_carga_req) begin
            o_grant = CARGA;
        end else if (i_dado_req && i_busca_req) begin
            // Alternate between data and fetch so neither starves.
            o_grant = i_ultimo_dado ? BUSCA : DADO;
        end else if (i_dado_req) begin
            o_grant = DADO;
        end else if (i_busca_req) begin
            o_grant = BUSCA;
        end
    end

endmodule

// File: rtl/arbitro_memoria.sv
// -----------------------------------------------------------------------------
// arbitro_memoria
// Single-port memory arbiter and access sequencer for the 8-bit nRisc.
// Shares one synchronous memory between the program loader (Carga), data
// load/store (Dado) and instruction fetch (Busca).
//
// Handshake: each requester holds its Req high until its completion pulse
// (CargaAck / DadoValido / BuscaValida). A pulse lasts exactly one cycle and
// occurs while the sequencer is back in OCIOSO; a Req still high at the edge
// ending that cycle is taken as a fresh request.
//
// Ports:
//   Clock, Reset (async, active-low)
//   CargaReq/CargaEndereco/CargaDado -> CargaAck
//   BuscaReq/BuscaEndereco           -> Instrucao, BuscaValida, Stall
//   DadoReq/DadoEscrever/DadoEndereco/DadoEscrito -> DadoLido, DadoValido
//   MemEndereco, MemDadoOut, MemRead, MemWrite <- MemDadoIn (memory side)
//   Ocupado       : sequencer not idle
//   DbgEstado     : current sequencer state
//   DbgUltimoDado : Dado/Busca fairness flag
// -----------------------------------------------------------------------------
module arbitro_memoria
    import arbitro_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       CargaReq,
    input  logic [7:0] CargaEndereco,
    input  logic [7:0] CargaDado,
    output logic       CargaAck,
    input  logic       BuscaReq,
    input  logic [7:0] BuscaEndereco,
    output logic [7:0] Instrucao,
    output logic       BuscaValida,
    input  logic       DadoReq,
    input  logic       DadoEscrever,
    input  logic [7:0] DadoEndereco,
    input  logic [7:0] DadoEscrito,
    output logic [7:0] DadoLido,
    output logic       DadoValido,
    output logic [7:0] MemEndereco,
    output logic [7:0] MemDadoOut,
    output logic       MemRead,
    output logic       MemWrite,
    input  logic [7:0] MemDadoIn,
    output logic       Stall,
    output logic       Ocupado,
    output logic [1:0] DbgEstado,
    output logic       DbgUltimoDado
);

    if (!mem_lat_valida(MEM_LAT)) begin : g_lat_invalida
        $error("arbitro_memoria: MEM_LAT must be in 1..4");
    end

    // ESPERA is entered with the counter at 1 and leaves once it reaches
    // MEM_LAT-1, giving MEM_LAT-1 wait cycles.
    localparam logic [1:0] CONT_FIM = 2'(MEM_LAT - 1);

    logic [1:0] r_estado;
    logic [1:0] r_grant;
    logic [7:0] r_endereco;
    logic [7:0] r_dado_wr;
    logic       r_escrever;
    logic       r_ultimo_dado;
    logic [1:0] r_contador;
    logic [7:0] r_instrucao;
    logic [7:0] r_dado_lido;
    logic       r_carga_ack;
    logic       r_busca_valida;
    logic       r_dado_valido;

    logic [1:0] w_grant;
    logic       w_acesso;
    logic       w_captura;
    logic       w_escrita_fim;

    seletor_prioridade u_seletor (
        .i_carga_req   (CargaReq),
        .i_dado_req    (DadoReq),
        .i_busca_req   (BuscaReq),
        .i_ultimo_dado (r_ultimo_dado),
        .o_grant       (w_grant)
    );

    assign w_acesso      = (r_estado == ACESSO);
    assign w_escrita_fim = w_acesso && r_escrever;
    // Read data is sampled either straight out of ACESSO (latency 1) or at
    // the last ESPERA cycle.
    assign w_captura = (w_acesso && !r_escrever && (MEM_LAT == 1)) ||
                       ((r_estado == ESPERA) && (r_contador == CONT_FIM));

    // Sequencer, grant latch and fairness flag
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_estado      <= OCIOSO;
            r_grant       <= NENHUM;
            r_endereco    <= 8'h00;
            r_dado_wr     <= 8'h00;
            r_escrever    <= 1'b0;
            r_ultimo_dado <= 1'b0;
            r_contador    <= 2'd0;
        end else begin
            case (r_estado)
                OCIOSO: begin
                    if (w_grant != NENHUM) begin
                        r_grant  <= w_grant;
                        r_estado <= ACESSO;
                        case (w_grant)
                            CARGA: begin
                                r_endereco <= CargaEndereco;
                                r_dado_wr  <= CargaDado;
                                r_escrever <= 1'b1;
                            end
                            DADO: begin
                                r_endereco    <= DadoEndereco;
                                r_dado_wr     <= DadoEscrever ? DadoEscrito : 8'h00;
                                r_escrever    <= DadoEscrever;
                                r_ultimo_dado <= 1'b1;
                            end
                            default: begin
                                r_endereco    <= BuscaEndereco;
                                r_dado_wr     <= 8'h00;
                                r_escrever    <= 1'b0;
                                r_ultimo_dado <= 1'b0;
                            end
                        endcase
                    end
                end
                ACESSO: begin
                    if (r_escrever || (MEM_LAT == 1)) begin
                        r_estado <= OCIOSO;
                    end else begin
                        r_estado   <= ESPERA;
                        r_contador <= 2'd1;
                    end
                end
                ESPERA: begin
                    if (r_contador == CONT_FIM) begin
                        r_estado   <= OCIOSO;
                        r_contador <= 2'd0;
                    end else begin
                        r_contador <= r_contador + 2'd1;
                    end
                end
                default: begin
                    r_estado   <= OCIOSO;
                    r_contador <= 2'd0;
                end
            endcase
        end
    end

    // Read capture and completion pulses. Only the register belonging to the
    // granted requester is loaded; the other keeps its last value.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_instrucao    <= 8'h00;
            r_dado_lido    <= 8'h00;
            r_carga_ack    <= 1'b0;
            r_busca_valida <= 1'b0;
            r_dado_valido  <= 1'b0;
        end else begin
            r_carga_ack    <= 1'b0;
            r_busca_valida <= 1'b0;
            r_dado_valido  <= 1'b0;
            if (w_escrita_fim) begin
                if (r_grant == CARGA) begin
                    r_carga_ack <= 1'b1;
                end else begin
                    r_dado_valido <= 1'b1;
                end
            end
            if (w_captura) begin
                if (r_grant == DADO) begin
                    r_dado_lido   <= MemDadoIn;
                    r_dado_valido <= 1'b1;
                end else begin
                    r_instrucao    <= MemDadoIn;
                    r_busca_valida <= 1'b1;
                end
            end
        end
    end

    // Memory side is driven only during ACESSO; everything is 0 otherwise.
    assign MemRead     = w_acesso && !r_escrever;
    assign MemWrite    = w_escrita_fim;
    assign MemEndereco = w_acesso ? r_endereco : 8'h00;
    assign MemDadoOut  = w_escrita_fim ? r_dado_wr : 8'h00;

    assign Instrucao     = r_instrucao;
    assign DadoLido      = r_dado_lido;
    assign CargaAck      = r_carga_ack;
    assign BuscaValida   = r_busca_valida;
    assign DadoValido    = r_dado_valido;
    assign Stall         = BuscaReq && !r_busca_valida;
    assign Ocupado       = (r_estado != OCIOSO);
    assign DbgEstado     = r_estado;
    assign DbgUltimoDado = r_ultimo_dado;

endmodule

// File: tb/tb_arbitro_memoria.sv
// -----------------------------------------------------------------------------
// tb_arbitro_memoria
// Directed bench for arbitro_memoria. A MEM_LAT=1 instance is checked through
// an event scoreboard (memory strobes and completion pulses) plus a few
// direct timing checks; a MEM_LAT=3 instance covers the latency path.
// -----------------------------------------------------------------------------
module tb_arbitro_memoria;

    localparam logic [3:0] K_RD  = 4'd1;
    localparam logic [3:0] K_WR  = 4'd2;
    localparam logic [3:0] K_ACK = 4'd3;
    localparam logic [3:0] K_BV  = 4'd4;
    localparam logic [3:0] K_DV  = 4'd5;

    // ---------------- clock / reset ----------------
    logic Clock = 1'b0;
    logic Reset = 1'b0;
    always #5 Clock = ~Clock;

    // ---------------- MEM_LAT=1 instance signals ----------------
    logic       CargaReq = 1'b0;
    logic [7:0] CargaEndereco = 8'h00;
    logic [7:0] CargaDado = 8'h00;
    logic       CargaAck;
    logic       BuscaReq = 1'b0;
    logic [7:0] BuscaEndereco = 8'h00;
    logic [7:0] Instrucao;
    logic       BuscaValida;
    logic       DadoReq = 1'b0;
    logic       DadoEscrever = 1'b0;
    logic [7:0] DadoEndereco = 8'h00;
    logic [7:0] DadoEscrito = 8'h00;
    logic [7:0] DadoLido;
    logic       DadoValido;
    logic [7:0] MemEndereco;
    logic [7:0] MemDadoOut;
    logic       MemRead;
    logic       MemWrite;
    logic [7:0] MemDadoIn;
    logic       Stall;
    logic       Ocupado;
    logic [1:0] DbgEstado;
    logic       DbgUltimoDado;

    // ---------------- MEM_LAT=3 instance signals ----------------
    logic       d3_DadoReq = 1'b0;
    logic [7:0] d3_DadoEndereco = 8'h00;
    logic       d3_CargaAck, d3_BuscaValida, d3_DadoValido;
    logic [7:0] d3_Instrucao, d3_DadoLido, d3_MemEndereco, d3_MemDadoOut;
    logic       d3_MemRead, d3_MemWrite, d3_Stall, d3_Ocupado, d3_DbgUltimoDado;
    logic [1:0] d3_DbgEstado;
    logic [7:0] d3_MemDadoIn;
    logic [7:0] d3_p1 = 8'h00;
    logic [7:0] d3_p2 = 8'h00;

    arbitro_memoria #(.MEM_LAT(1)) dut (
        .Clock(Clock), .Reset(Reset),
        .CargaReq(CargaReq), .CargaEndereco(CargaEndereco), .CargaDado(CargaDado), .CargaAck(CargaAck),
        .BuscaReq(BuscaReq), .BuscaEndereco(BuscaEndereco), .Instrucao(Instrucao), .BuscaValida(BuscaValida),
        .DadoReq(DadoReq), .DadoEscrever(DadoEscrever), .DadoEndereco(DadoEndereco), .DadoEscrito(DadoEscrito),
        .DadoLido(DadoLido), .DadoValido(DadoValido),
        .MemEndereco(MemEndereco), .MemDadoOut(MemDadoOut), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemDadoIn(MemDadoIn), .Stall(Stall), .Ocupado(Ocupado),
        .DbgEstado(DbgEstado), .DbgUltimoDado(DbgUltimoDado)
    );

    arbitro_memoria #(.MEM_LAT(3)) dut3 (
        .Clock(Clock), .Reset(Reset),
        .CargaReq(1'b0), .CargaEndereco(8'h00), .CargaDado(8'h00), .CargaAck(d3_CargaAck),
        .BuscaReq(1'b0), .BuscaEndereco(8'h00), .Instrucao(d3_Instrucao), .BuscaValida(d3_BuscaValida),
        .DadoReq(d3_DadoReq), .DadoEscrever(1'b0), .DadoEndereco(d3_DadoEndereco), .DadoEscrito(8'h00),
        .DadoLido(d3_DadoLido), .DadoValido(d3_DadoValido),
        .MemEndereco(d3_MemEndereco), .MemDadoOut(d3_MemDadoOut), .MemRead(d3_MemRead), .MemWrite(d3_MemWrite),
        .MemDadoIn(d3_MemDadoIn), .Stall(d3_Stall), .Ocupado(d3_Ocupado),
        .DbgEstado(d3_DbgEstado), .DbgUltimoDado(d3_DbgUltimoDado)
    );

    // ---------------- memory models ----------------
    logic [7:0] mem [256];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        mem[8'h10] <= 8'hA5;
        mem[8'h20] <= 8'h42;
        mem[8'h21] <= 8'h9C;
        mem[8'h30] <= 8'h77;
        mem[8'h31] <= 8'h18;
    end

    always @(posedge Clock) begin
        if (MemWrite) mem[MemEndereco] <= MemDadoOut;
    end

    // Latency 1: data must be present during the read cycle itself.
    assign MemDadoIn = MemRead ? mem[MemEndereco] : 8'h00;

    // Latency 3: two pipeline stages after the read strobe.
    always @(posedge Clock) begin
        d3_p1 <= d3_MemRead ? mem[d3_MemEndereco] : 8'h00;
        d3_p2 <= d3_p1;
    end
    assign d3_MemDadoIn = d3_p2;

    // ---------------- scoreboard ----------------
    logic [19:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    function automatic logic [19:0] ev(input logic [3:0] k, input logic [7:0] a, input logic [7:0] d);
        return {k, a, d};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: every strobe or completion pulse of the latency-1 instance must
    // match the next expected event.
    initial begin
        logic [19:0] obs;
        logic [19:0] exp;
        bit have;
        forever begin
            @(negedge Clock);
            have = 1'b1;
            if (MemRead)          obs = {K_RD, MemEndereco, MemDadoOut};
            else if (MemWrite)    obs = {K_WR, MemEndereco, MemDadoOut};
            else if (CargaAck)    obs = {K_ACK, 16'h0000};
            else if (BuscaValida) obs = {K_BV, 8'h00, Instrucao};
            else if (DadoValido)  obs = {K_DV, 8'h00, DadoLido};
            else                  have = 1'b0;
            if (have) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard: got event %h expected none", obs);
                end else begin
                    exp = exp_q.pop_front();
                    if (obs !== exp) begin
                        errors++;
                        $display("FAIL scoreboard: got event %h expected %h", obs, exp);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Holds each request until it has completed the given number of times.
    task automatic serve(input int nc, input int nd, input int nb);
        int cyc = 0;
        while ((nc > 0 || nd > 0 || nb > 0) && cyc < 60) begin
            @(negedge Clock);
            cyc++;
            if (CargaAck)    begin nc--; if (nc <= 0) CargaReq = 1'b0; end
            if (DadoValido)  begin nd--; if (nd <= 0) DadoReq  = 1'b0; end
            if (BuscaValida) begin nb--; if (nb <= 0) BuscaReq = 1'b0; end
        end
        chk("serve_timeout", {29'd0, (nc > 0), (nd > 0), (nb > 0)}, 32'd0);
        CargaReq = 1'b0;
        DadoReq  = 1'b0;
        BuscaReq = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int rd_cnt;
        int oc_cnt;
        int dv_cyc;
        int dv_cnt;

        // Power-on reset
        repeat (2) @(negedge Clock);
        chk("reset_mem", {MemRead, MemWrite, MemEndereco, MemDadoOut}, 0);
        chk("reset_regs", {Instrucao, DadoLido, CargaAck, BuscaValida, DadoValido}, 0);
        Reset = 1'b1;
        @(negedge Clock);
        chk("reset_idle", {Ocupado, DbgEstado, DbgUltimoDado, Stall}, 0);

        // Fetch 0x10 with latency 1
        exp_q.push_back(ev(K_RD, 8'h10, 8'h00));
        exp_q.push_back(ev(K_BV, 8'h00, 8'hA5));
        BuscaEndereco = 8'h10;
        BuscaReq = 1'b1;
        #1 chk("fetch_stall_rise", Stall, 1);
        @(negedge Clock);
        chk("fetch_acesso_read", {MemRead, MemEndereco}, {1'b1, 8'h10});
        chk("fetch_acesso_stall", {Stall, BuscaValida}, {1'b1, 1'b0});
        @(negedge Clock);
        chk("fetch_valid", {BuscaValida, Instrucao}, {1'b1, 8'hA5});
        chk("fetch_stall_low", Stall, 0);
        BuscaReq = 1'b0;
        @(negedge Clock);
        chk("fetch_after", {BuscaValida, MemRead, Ocupado}, 0);

        // Dado and Busca together: Dado first (flag is 0)
        exp_q.push_back(ev(K_RD, 8'h20, 8'h00));
        exp_q.push_back(ev(K_DV, 8'h00, 8'h42));
        exp_q.push_back(ev(K_RD, 8'h21, 8'h00));
        exp_q.push_back(ev(K_BV, 8'h00, 8'h9C));
        DadoEscrever = 1'b0;
        DadoEndereco = 8'h20;
        DadoReq = 1'b1;
        BuscaEndereco = 8'h21;
        BuscaReq = 1'b1;
        serve(0, 1, 1);

        // Both kept asserted for four grants: D, B, D, B
        @(negedge Clock);
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(ev(K_RD, 8'h30, 8'h00));
            exp_q.push_back(ev(K_DV, 8'h00, 8'h77));
            exp_q.push_back(ev(K_RD, 8'h31, 8'h00));
            exp_q.push_back(ev(K_BV, 8'h00, 8'h18));
        end
        DadoEndereco = 8'h30;
        DadoReq = 1'b1;
        BuscaEndereco = 8'h31;
        BuscaReq = 1'b1;
        serve(0, 2, 2);
        chk("alternate_flag", DbgUltimoDado, 0);

        // Loader write with a store and a fetch pending; fetch reads back the load
        @(negedge Clock);
        exp_q.push_back(ev(K_WR, 8'h05, 8'h3C));
        exp_q.push_back(ev(K_ACK, 8'h00, 8'h00));
        exp_q.push_back(ev(K_WR, 8'h06, 8'h5E));
        exp_q.push_back(ev(K_DV, 8'h00, 8'h77));
        exp_q.push_back(ev(K_RD, 8'h05, 8'h00));
        exp_q.push_back(ev(K_BV, 8'h00, 8'h3C));
        CargaEndereco = 8'h05;
        CargaDado = 8'h3C;
        CargaReq = 1'b1;
        DadoEscrever = 1'b1;
        DadoEndereco = 8'h06;
        DadoEscrito = 8'h5E;
        DadoReq = 1'b1;
        BuscaEndereco = 8'h05;
        BuscaReq = 1'b1;
        serve(1, 1, 1);
        DadoEscrever = 1'b0;

        // Load back the stored byte
        @(negedge Clock);
        exp_q.push_back(ev(K_RD, 8'h06, 8'h00));
        exp_q.push_back(ev(K_DV, 8'h00, 8'h5E));
        DadoEndereco = 8'h06;
        DadoReq = 1'b1;
        serve(0, 1, 0);

        // Reset in the middle of a read of 0x10
        @(negedge Clock);
        exp_q.push_back(ev(K_RD, 8'h10, 8'h00));
        DadoEndereco = 8'h10;
        DadoReq = 1'b1;
        @(negedge Clock);
        chk("midreset_acesso", {MemRead, MemEndereco, DbgUltimoDado}, {1'b1, 8'h10, 1'b1});
        #2 Reset = 1'b0;
        #1;
        chk("midreset_mem", {MemRead, MemWrite, MemEndereco, MemDadoOut}, 0);
        chk("midreset_regs", {Instrucao, DadoLido}, 0);
        chk("midreset_state", {Ocupado, DbgEstado, DbgUltimoDado}, 0);
        DadoReq = 1'b0;
        repeat (3) begin
            @(negedge Clock);
            chk("midreset_no_pulse", {CargaAck, BuscaValida, DadoValido}, 0);
        end
        Reset = 1'b1;
        repeat (2) begin
            @(negedge Clock);
            chk("postreset_idle", {Ocupado, DbgUltimoDado, CargaAck, BuscaValida, DadoValido}, 0);
        end

        // MEM_LAT=3 load of 0x20
        d3_DadoEndereco = 8'h20;
        d3_DadoReq = 1'b1;
        rd_cnt = 0;
        oc_cnt = 0;
        dv_cyc = 0;
        dv_cnt = 0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge Clock);
            if (d3_MemRead) rd_cnt++;
            if (d3_Ocupado) oc_cnt++;
            if (d3_DadoValido) begin
                dv_cnt++;
                dv_cyc = c;
                chk("lat3_data", d3_DadoLido, 8'h42);
                d3_DadoReq = 1'b0;
            end
        end
        d3_DadoReq = 1'b0;
        chk("lat3_read_cycles", rd_cnt, 1);
        chk("lat3_busy_cycles", oc_cnt, 3);
        chk("lat3_valid_cycle", dv_cyc, 4);
        chk("lat3_valid_count", dv_cnt, 1);

        repeat (3) @(negedge Clock);
        chk("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/arbitro_memoria.md
# arbitro_memoria

Single-port memory arbiter and access sequencer for the 8-bit nRisc. It shares one unified synchronous memory between three requesters: instruction fetch, data load/store, and an external program loader. It sequences each access through a small state machine and returns read data with a valid pulse. It also drives a stall flag that the top level uses to gate PC writes while a fetch is outstanding.

## Interface
- MEM_LAT, 1: memory read latency in cycles, legal range 1..4.
- Clock  in  1  single clock, rising edge.
- Reset  in  1  asynchronous, active-low.
- CargaReq  in  1  loader write request, held until CargaAck.
- CargaEndereco  in  8  loader write address.
- CargaDado  in  8  loader write data.
- CargaAck  out  1  one-cycle pulse when the loader write completes.
- BuscaReq  in  1  instruction fetch request, held until BuscaValida.
- BuscaEndereco  in  8  fetch address (PC).
- Instrucao  out  8  fetched instruction, registered.
- BuscaValida  out  1  one-cycle pulse; Instrucao is valid in this cycle.
- DadoReq  in  1  data access request, held until DadoValido.
- DadoEscrever  in  1  1 = store, 0 = load.
- DadoEndereco  in  8  data address.
- DadoEscrito  in  8  store data.
- DadoLido  out  8  load result, registered.
- DadoValido  out  1  one-cycle pulse on load data return or store completion.
- MemEndereco  out  8  memory address.
- MemDadoOut  out  8  memory write data.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- MemDadoIn  in  8  memory read data.
- Stall  out  1  BuscaReq & ~BuscaValida, combinational.
- Ocupado  out  1  high whenever the state is not OCIOSO.

## Operation
- States:
  - OCIOSO: sample requests. On a grant, latch grant, address, write data and direction, then go to ACESSO.
  - ACESSO: drive the memory from the latched registers for exactly one cycle. A write returns to OCIOSO. A read goes to ESPERA when MEM_LAT>1; when MEM_LAT=1 it returns to OCIOSO and captures the data.
  - ESPERA: count MEM_LAT-1 cycles, then capture MemDadoIn and return to OCIOSO.
- Priority in OCIOSO:
  - Carga beats everything else.
  - Between Dado and Busca, a 1-bit flag ultimo_dado decides. It is set on a Dado grant and cleared on a Busca grant. On contention, Busca wins if ultimo_dado=1, otherwise Dado wins.
  - A lone request always wins.
- Carga is always a write.
- Read data capture: the Dado grant loads DadoLido and the Busca grant loads Instrucao. The other register holds its value.
- A completion pulse (CargaAck, BuscaValida or DadoValido) is high exactly one cycle, in the cycle after the capture or write edge; the state is then OCIOSO.
- A request still high at the edge ending its completion cycle counts as a new request.
- A request dropped after grant: the access still completes and still pulses.
- Memory strobes are 0 outside ACESSO. MemDadoOut is 0 on reads.
- Reset low, at any time including mid-access:
  - state becomes OCIOSO immediately and asynchronously; the in-flight access is abandoned with no pulse.
  - MemRead, MemWrite, every pulse, Instrucao, DadoLido, MemEndereco, MemDadoOut, the counter and ultimo_dado are all 0.

## Timing
- Let edge 0 be the edge that samples a request in OCIOSO.
- ACESSO spans edge 0 to edge 1.
- Write: the write commits at edge 1 and the ack is high from edge 1 to edge 2.
- Read: capture at edge MEM_LAT; valid is high from edge MEM_LAT to edge MEM_LAT+1.
- Minimum spacing between back-to-back grants is 2 cycles for writes and MEM_LAT+1 for reads.
- Stall stays high from BuscaReq rising until the BuscaValida cycle, where it is low.

## Structure
- Shared package arbitro_pkg holds:
  - state encoding OCIOSO=0, ACESSO=1, ESPERA=2;
  - grant encoding NENHUM=0, CARGA=1, DADO=2, BUSCA=3;
  - MEM_LAT bounds and an elaboration check for the legal range.
- Sub-module seletor_prioridade: combinational grant select from CargaReq, DadoReq, BuscaReq and ultimo_dado. The FSM, latency counter and capture registers stay in the top.

## Test plan
- Reset low while ACESSO reads 0x10: MemRead drops immediately, all outputs are 0, and there is no pulse. After release, Ocupado=0 and ultimo_dado=0.
- MEM_LAT=1, BuscaReq to 0x10, memory returns 0xA5: MemRead=1 with MemEndereco=0x10 for one cycle. BuscaValida is high 1 cycle after the sample edge with Instrucao=0xA5. Stall is 1 until that cycle.
- DadoReq load 0x20 and BuscaReq 0x21 asserted together and held until served: Dado is granted first and DadoLido gets mem[0x20]; Busca is granted next.
- Both requests kept re-asserted for 4 grants: grant order is Dado, Busca, Dado, Busca.
- CargaReq write 0x3C to 0x05 with Dado and Busca pending: MemWrite=1, MemEndereco=0x05, MemDadoOut=0x3C first, then a CargaAck pulse, then Dado.
- MEM_LAT=3 load: MemRead is high exactly 1 cycle. DadoValido is high edge 3 to edge 4 with the correct data. Ocupado is high 3 cycles.
